// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// Define ARB_RR_EN for round-robin tie-breaking; fixed D-first priority otherwise.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_wmask,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wmask,
    input  logic [DW-1:0]     m_rdata,
    input  logic              m_ready,
    output logic              stall,
    output logic              grant_d,
    output logic              bus_err
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] wd_cnt;
    logic          win_d;
    logic          wd_expired;

`ifdef ARB_RR_EN
    logic last_d;

    // On a tie, the requester that did not win last time goes first.
    assign win_d = d_req & (~i_req | ~last_d);
`else
    assign win_d = d_req;
`endif

    assign stall      = (i_req & ~i_ack) | (d_req & ~d_ack);
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wmask <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            grant_d <= 1'b0;
            bus_err <= 1'b0;
            i_rdata <= NOP;
            d_rdata <= '0;
            wd_cnt  <= '0;
`ifdef ARB_RR_EN
            last_d  <= 1'b1;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state   <= BUSY;
                        m_req   <= 1'b1;
                        grant_d <= win_d;
`ifdef ARB_RR_EN
                        last_d  <= win_d;
`endif
                        if (win_d) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_wmask <= d_wmask;
                        end else begin
                            m_we    <= 1'b0;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_wmask <= MW'(0);
                        end
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        state  <= RESP;
                        m_req  <= 1'b0;
                        wd_cnt <= '0;
                        if (grant_d) begin
                            d_ack <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else if (wd_expired) begin
                        // Abort a hung access: complete it with zero data and flag the error.
                        state   <= RESP;
                        m_req   <= 1'b0;
                        wd_cnt  <= '0;
                        bus_err <= 1'b1;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        stall;
    logic        grant_d;
    logic        bus_err;

    int passed = 0;
    int total  = 0;
    bit model_last_d = 1'b1;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata), .m_ready(m_ready),
        .stall(stall), .grant_d(grant_d), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic bit tie_winner_d(input bit last_d);
        return RR ? ~last_d : 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wmask = 0;
        m_ready = 0; m_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_last_d = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_req !== 1'b0) $display("FAIL reset_m_req got %0b exp 0", m_req); else passed++;
        total++; if ({m_we, m_wmask} !== 5'b0) $display("FAIL reset_m_we_mask got %b exp 0", {m_we, m_wmask}); else passed++;
        total++; if (m_addr !== 32'h0) $display("FAIL reset_m_addr got %h exp 0", m_addr); else passed++;
        total++; if ({i_ack, d_ack, grant_d, bus_err} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {i_ack, d_ack, grant_d, bus_err}); else passed++;
        total++; if (i_rdata !== 32'h13) $display("FAIL reset_i_rdata got %h exp 00000013", i_rdata); else passed++;
        total++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata got %h exp 0", d_rdata); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b exp 0", stall); else passed++;
    endtask

    task automatic test_fetch();
        i_req = 1; i_addr = 32'h100;
        @(negedge clk);
        total++; if ({m_req, m_we} !== 2'b10) $display("FAIL fetch_c1_req_we got %b exp 10", {m_req, m_we}); else passed++;
        total++; if (m_addr !== 32'h100) $display("FAIL fetch_c1_addr got %h exp 100", m_addr); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL fetch_c1_stall got %0b exp 1", stall); else passed++;
        m_ready = 1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (i_ack !== 1'b1) $display("FAIL fetch_c2_ack got %0b exp 1", i_ack); else passed++;
        total++; if (i_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_c2_rdata got %h exp deadbeef", i_rdata); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL fetch_c2_stall got %0b exp 0", stall); else passed++;
        i_req = 0; m_ready = 0;
        @(negedge clk);
        total++; if (i_ack !== 1'b0) $display("FAIL fetch_c3_ack_pulse got %0b exp 0", i_ack); else passed++;
        model_last_d = 1'b0;
    endtask

    task automatic test_priority();
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hAA; d_wmask = 4'hF;
        @(negedge clk);
        total++; if ({m_req, m_we, grant_d} !== 3'b111) $display("FAIL prio_c1_req_we_grant got %b exp 111", {m_req, m_we, grant_d}); else passed++;
        total++; if (m_addr !== 32'h200 || m_wdata !== 32'hAA || m_wmask !== 4'hF)
            $display("FAIL prio_c1_payload got %h/%h/%h exp 200/aa/f", m_addr, m_wdata, m_wmask); else passed++;
        m_ready = 1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        total++; if ({d_ack, i_ack} !== 2'b10) $display("FAIL prio_c2_acks got %b exp 10", {d_ack, i_ack}); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL prio_c2_stall got %0b exp 1", stall); else passed++;
        d_req = 0; d_we = 0;
        @(negedge clk);
        total++; if (m_req !== 1'b0) $display("FAIL prio_c3_m_req got %0b exp 0", m_req); else passed++;
        @(negedge clk);
        total++; if ({m_req, m_we, m_wmask} !== 6'b100000 || m_addr !== 32'h104)
            $display("FAIL prio_c4_fetch got req/we/mask %b addr %h exp 100000 104", {m_req, m_we, m_wmask}, m_addr); else passed++;
        @(negedge clk);
        total++; if (i_ack !== 1'b1 || i_rdata !== 32'h1234_5678)
            $display("FAIL prio_c5_fetch_ack got %0b %h exp 1 12345678", i_ack, i_rdata); else passed++;
        i_req = 0; m_ready = 0;
        @(negedge clk);
        model_last_d = 1'b0;
    endtask

    task automatic test_wait_states();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = 32'h5A5A_5A5A; d_wmask = 4'h3;
        m_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if (m_req !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'h5A5A_5A5A || d_ack !== 1'b0)
                $display("FAIL wait_c%0d got req %0b addr %h wdata %h ack %0b exp 1 40 5a5a5a5a 0", k, m_req, m_addr, m_wdata, d_ack); else passed++;
            if (k == 4) begin
                m_ready = 1; m_rdata = 32'h0000_CAFE;
            end
        end
        @(negedge clk);
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'h0000_CAFE)
            $display("FAIL wait_c5_ack got %0b %h exp 1 0000cafe", d_ack, d_rdata); else passed++;
        d_req = 0; m_ready = 0;
        @(negedge clk);
        model_last_d = 1'b1;
    endtask

    task automatic test_watchdog();
        i_req = 1; i_addr = 32'h300; m_ready = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++; if (m_req !== 1'b1 || i_ack !== 1'b0 || bus_err !== 1'b0)
                $display("FAIL wdog_c%0d got req %0b ack %0b err %0b exp 1 0 0", k, m_req, i_ack, bus_err); else passed++;
        end
        @(negedge clk);
        total++; if (i_ack !== 1'b1 || i_rdata !== 32'h0 || bus_err !== 1'b1)
            $display("FAIL wdog_c9_abort got ack %0b rdata %h err %0b exp 1 0 1", i_ack, i_rdata, bus_err); else passed++;
        i_req = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h44;
        @(negedge clk);
        m_ready = 1; m_rdata = 32'h77;
        @(negedge clk);
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'h77 || bus_err !== 1'b1)
            $display("FAIL wdog_sticky got ack %0b rdata %h err %0b exp 1 77 1", d_ack, d_rdata, bus_err); else passed++;
        d_req = 0; m_ready = 0;
        @(negedge clk);
        model_last_d = 1'b1;
    endtask

    task automatic test_reset_busy();
        i_req = 1; i_addr = 32'h500; m_ready = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        total++; if ({m_req, i_ack, d_ack, bus_err} !== 4'b0 || i_rdata !== 32'h13)
            $display("FAIL rst_busy_c3 got req/acks/err %b rdata %h exp 0000 00000013", {m_req, i_ack, d_ack, bus_err}, i_rdata); else passed++;
        reset = 0;
        model_last_d = 1'b1;
        @(negedge clk);
        total++; if (m_req !== 1'b1 || m_addr !== 32'h500)
            $display("FAIL rst_busy_regrant got req %0b addr %h exp 1 500", m_req, m_addr); else passed++;
        m_ready = 1; m_rdata = 32'h9;
        @(negedge clk);
        total++; if (i_ack !== 1'b1 || i_rdata !== 32'h9)
            $display("FAIL rst_busy_ack got %0b %h exp 1 9", i_ack, i_rdata); else passed++;
        i_req = 0; m_ready = 0;
        @(negedge clk);
        model_last_d = 1'b0;
    endtask

    task automatic test_both_held();
        bit exp_d;
        bit last;
        do_reset();
        last = 1'b1;
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h10;
        m_ready = 1; m_rdata = 32'h55;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2 || c == 5 || c == 8 || c == 11) begin
                exp_d = tie_winner_d(last);
                last = exp_d;
                total++; if ({d_ack, i_ack} !== {exp_d, ~exp_d})
                    $display("FAIL held_c%0d got d/i ack %b exp %b", c, {d_ack, i_ack}, {exp_d, ~exp_d}); else passed++;
            end else begin
                total++; if ({d_ack, i_ack} !== 2'b00)
                    $display("FAIL held_c%0d_noack got %b exp 00", c, {d_ack, i_ack}); else passed++;
            end
        end
        i_req = 0; d_req = 0; m_ready = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] mem [16];
        logic [31:0] ref_mem [16];
        bit pend_i, pend_d, exp_d, we;
        logic [3:0] ia, da, idx, wm;
        logic [31:0] wd;
        int wait_left, cyc;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        for (int it = 0; it < 40; it++) begin
            pend_i = 1'($urandom_range(0, 1));
            pend_d = 1'($urandom_range(0, 1));
            if (!pend_i && !pend_d) pend_d = 1'b1;
            ia = 4'($urandom_range(0, 15));
            da = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            wm = 4'($urandom);
            i_req = pend_i; i_addr = {26'b0, ia, 2'b00};
            d_req = pend_d; d_we = we; d_addr = {26'b0, da, 2'b00}; d_wdata = wd; d_wmask = wm;
            wait_left = $urandom_range(0, 3);
            cyc = 0;
            while ((pend_i || pend_d) && cyc < 60) begin
                @(negedge clk);
                cyc++;
                if (i_ack || d_ack) begin
                    exp_d = (pend_i && pend_d) ? tie_winner_d(model_last_d) : pend_d;
                    model_last_d = exp_d;
                    total++; if ({d_ack, i_ack} !== {exp_d, ~exp_d})
                        $display("FAIL rand_%0d_winner got d/i ack %b exp %b", it, {d_ack, i_ack}, {exp_d, ~exp_d}); else passed++;
                    if (exp_d) begin
                        if (!we) begin
                            total++; if (d_rdata !== ref_mem[da])
                                $display("FAIL rand_%0d_load got %h exp %h", it, d_rdata, ref_mem[da]); else passed++;
                        end else begin
                            for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
                        end
                        pend_d = 0; d_req = 0;
                    end else begin
                        total++; if (i_rdata !== ref_mem[ia])
                            $display("FAIL rand_%0d_fetch got %h exp %h", it, i_rdata, ref_mem[ia]); else passed++;
                        pend_i = 0; i_req = 0;
                    end
                end
                m_ready = 0;
                if (m_req) begin
                    if (wait_left == 0) begin
                        idx = m_addr[5:2];
                        m_ready = 1;
                        m_rdata = mem[idx];
                        if (m_we) for (int b = 0; b < 4; b++) if (m_wmask[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
                        wait_left = $urandom_range(0, 3);
                    end else begin
                        wait_left--;
                    end
                end
            end
            if (pend_i || pend_d) begin
                total++;
                $display("FAIL rand_%0d_timeout pending i/d %b exp 00", it, {pend_i, pend_d});
                i_req = 0; d_req = 0;
                do_reset();
            end
        end
        m_ready = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            total++; if (mem[i] !== ref_mem[i])
                $display("FAIL rand_mem_%0d got %h exp %h", i, mem[i], ref_mem[i]); else passed++;
        end
        total++; if (bus_err !== 1'b0) $display("FAIL rand_bus_err got %0b exp 0", bus_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_wait_states();
        test_watchdog();
        test_reset_busy();
        test_both_held();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
